// File: rtl/keypad_entry_controller_pkg.sv
// Shared constants for the keypad entry path: FSM encoding, bus widths and
// the one-hot test used to accept a single key.
package keypad_entry_controller_pkg;

    localparam int KEY_W = 10;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] DEBOUNCE     = 2'd1;
    localparam logic [1:0] CAPTURE      = 2'd2;
    localparam logic [1:0] WAIT_RELEASE = 2'd3;

    // True when exactly one key bit is set.
    function automatic logic is_onehot(input logic [KEY_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/keypad_entry_controller_bcd_shift_reg4.sv
// Four-digit MM:SS entry register. New digits enter at seconds-ones and push
// the older digits left; the oldest minutes-tens digit falls off the end.
module keypad_entry_controller_bcd_shift_reg4
    import keypad_entry_controller_pkg::*;
(
    input  logic             clock,
    input  logic             clearn,
    input  logic             clear_entry,
    input  logic             shift_en,
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] sec_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] min_tens,
    output logic             digit_strobe
);

    // Digit shift with clear taking priority; a cleared shift gets no strobe.
    always_ff @(posedge clock) begin
        if (!clearn) begin
            sec_ones     <= '0;
            sec_tens     <= '0;
            min_ones     <= '0;
            min_tens     <= '0;
            digit_strobe <= 1'b0;
        end else if (clear_entry) begin
            sec_ones     <= '0;
            sec_tens     <= '0;
            min_ones     <= '0;
            min_tens     <= '0;
            digit_strobe <= 1'b0;
        end else begin
            digit_strobe <= shift_en;
            if (shift_en) begin
                min_tens <= min_ones;
                min_ones <= sec_tens;
                sec_tens <= sec_ones;
                sec_ones <= din;
            end
        end
    end

endmodule

// File: rtl/keypad_entry_controller.sv
// Keypad front end for microwave time entry: registers and debounces the
// keypad, pulses the BCD encoder once per accepted key, and shifts the
// returned digit into the entry register.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | waiting for a single key while unlocked
// DEBOUNCE     | counting cycles the captured pattern stays unchanged
// CAPTURE      | encoder enabled for one cycle, digit sampled on exit
// WAIT_RELEASE | digit taken; wait for all keys released before re-arming
module keypad_entry_controller
    import keypad_entry_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic             clock,
    input  logic             clearn,
    input  logic [KEY_W-1:0] keyboard,
    input  logic             lock,
    input  logic             clear_entry,
    output logic [KEY_W-1:0] enc_keyboard,
    output logic             enc_enablen,
    input  logic [BCD_W-1:0] enc_bcd,
    output logic [BCD_W-1:0] sec_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] min_tens,
    output logic             digit_strobe,
    output logic             entry_nonzero
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       state;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] pat;
    logic [CNT_W-1:0] cnt;
    logic             shift_en;

    // Input register; also the pattern presented to the encoder.
    always_ff @(posedge clock) begin
        if (!clearn) key_q <= '0;
        else         key_q <= keyboard;
    end

    // Sequencing FSM with the debounce counter.
    always_ff @(posedge clock) begin
        if (!clearn) begin
            state <= IDLE;
            pat   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_onehot(key_q) && !lock) begin
                        state <= DEBOUNCE;
                        pat   <= key_q;
                        cnt   <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (lock || (key_q != pat)) state <= IDLE;
                    else if (cnt == CNT_LAST)   state <= CAPTURE;
                    else                        cnt   <= cnt + 1'b1;
                end
                CAPTURE:      state <= WAIT_RELEASE;
                WAIT_RELEASE: if (key_q == '0) state <= IDLE;
                default:      state <= IDLE;
            endcase
        end
    end

    assign enc_keyboard  = key_q;
    assign enc_enablen   = (state != CAPTURE);
    // Out-of-range encoder codes and a late lock both drop the digit.
    assign shift_en      = (state == CAPTURE) && (enc_bcd <= BCD_MAX) && !lock;
    assign entry_nonzero = |{min_tens, min_ones, sec_tens, sec_ones};

    keypad_entry_controller_bcd_shift_reg4 u_digits (
        .clock        (clock),
        .clearn       (clearn),
        .clear_entry  (clear_entry),
        .shift_en     (shift_en),
        .din          (enc_bcd),
        .sec_ones     (sec_ones),
        .sec_tens     (sec_tens),
        .min_ones     (min_ones),
        .min_tens     (min_tens),
        .digit_strobe (digit_strobe)
    );

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Directed bench for keypad_entry_controller with a behavioural BCD encoder.
module tb_keypad_entry_controller;
    import keypad_entry_controller_pkg::*;

    logic        clock = 1'b0;
    logic        clearn = 1'b0;
    logic [9:0]  keyboard = '0;
    logic        lock = 1'b0;
    logic        clear_entry = 1'b0;
    logic [9:0]  enc_keyboard;
    logic        enc_enablen;
    logic [3:0]  enc_bcd;
    logic [3:0]  sec_ones, sec_tens, min_ones, min_tens;
    logic        digit_strobe;
    logic        entry_nonzero;
    logic        bad_mode = 1'b0;
    logic [15:0] digits;

    int n_cmp = 0;
    int n_bad = 0;
    int strobes = 0;
    int en_lows = 0;
    int s0, e0;
    logic [15:0] snap;

    always #5 clock = ~clock;

    keypad_entry_controller dut (
        .clock(clock), .clearn(clearn), .keyboard(keyboard), .lock(lock),
        .clear_entry(clear_entry), .enc_keyboard(enc_keyboard),
        .enc_enablen(enc_enablen), .enc_bcd(enc_bcd), .sec_ones(sec_ones),
        .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
        .digit_strobe(digit_strobe), .entry_nonzero(entry_nonzero)
    );

    assign digits = {min_tens, min_ones, sec_tens, sec_ones};

    // Encoder model: index of the set key while enabled, 0xF when idle.
    always_comb begin
        enc_bcd = 4'hF;
        if (!enc_enablen) begin
            if (bad_mode) enc_bcd = 4'hC;
            else for (int i = 0; i < 10; i++) if (enc_keyboard[i]) enc_bcd = 4'(i);
        end
    end

    always @(negedge clock) begin
        if (digit_strobe === 1'b1) strobes++;
        if (enc_enablen === 1'b0) en_lows++;
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic press(input logic [9:0] k, input int hold, input int gap);
        keyboard = k;
        repeat (hold) tick();
        keyboard = '0;
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        clearn = 1'b0; tick(); tick(); clearn = 1'b1; tick();
    endtask

    task automatic test_reset();
        clearn = 1'b0; keyboard = 10'h3FF; lock = 1'b0;
        tick(); tick();
        n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL reset_digits: got %h expected 0000", digits); end
        n_cmp++; if (digit_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b expected 0", digit_strobe); end
        n_cmp++; if (enc_enablen !== 1'b1) begin n_bad++; $display("FAIL reset_enablen: got %b expected 1", enc_enablen); end
        n_cmp++; if (enc_keyboard !== 10'h000) begin n_bad++; $display("FAIL reset_enc_keyboard: got %h expected 000", enc_keyboard); end
        n_cmp++; if (entry_nonzero !== 1'b0) begin n_bad++; $display("FAIL reset_nonzero: got %b expected 0", entry_nonzero); end
        keyboard = '0; clearn = 1'b1; tick();
    endtask

    task automatic test_single_digit();
        s0 = strobes; e0 = en_lows;
        keyboard = 10'b0000000100;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 0) begin
                n_cmp++; if (enc_keyboard !== 10'b0000000100) begin n_bad++; $display("FAIL single_enc_keyboard: got %b expected 0000000100", enc_keyboard); end
            end
            if (k == 5) begin
                n_cmp++; if (enc_enablen !== 1'b0) begin n_bad++; $display("FAIL single_enablen_e5: got %b expected 0", enc_enablen); end
                n_cmp++; if (digit_strobe !== 1'b0 || sec_ones !== 4'd0) begin n_bad++; $display("FAIL single_early_e5: strobe %b sec_ones %0d expected 0 0", digit_strobe, sec_ones); end
            end
            if (k == 6) begin
                n_cmp++; if (digit_strobe !== 1'b1) begin n_bad++; $display("FAIL single_strobe_e6: got %b expected 1", digit_strobe); end
                n_cmp++; if (sec_ones !== 4'd2) begin n_bad++; $display("FAIL single_sec_ones_e6: got %0d expected 2", sec_ones); end
            end
        end
        keyboard = '0;
        repeat (4) tick();
        n_cmp++; if (strobes - s0 !== 1) begin n_bad++; $display("FAIL single_strobe_count: got %0d expected 1", strobes - s0); end
        n_cmp++; if (en_lows - e0 !== 1) begin n_bad++; $display("FAIL single_enablen_count: got %0d expected 1", en_lows - e0); end
        n_cmp++; if (digits !== 16'h0002) begin n_bad++; $display("FAIL single_digits: got %h expected 0002", digits); end
    endtask

    task automatic test_sequence();
        do_reset();
        s0 = strobes;
        press(10'b0000000010, 8, 3);
        press(10'b0000000100, 8, 3);
        press(10'b0000001000, 8, 3);
        press(10'b0000000001, 8, 3);
        n_cmp++; if (digits !== 16'h1230) begin n_bad++; $display("FAIL seq_digits: got %h expected 1230", digits); end
        n_cmp++; if (entry_nonzero !== 1'b1) begin n_bad++; $display("FAIL seq_nonzero: got %b expected 1", entry_nonzero); end
        n_cmp++; if (strobes - s0 !== 4) begin n_bad++; $display("FAIL seq_strobe_count: got %0d expected 4", strobes - s0); end
        press(10'b0010000000, 8, 3);
        n_cmp++; if (digits !== 16'h2307) begin n_bad++; $display("FAIL overflow_digits: got %h expected 2307", digits); end
    endtask

    task automatic test_bounce();
        snap = digits; s0 = strobes; e0 = en_lows;
        keyboard = 10'b0000100000; tick(); tick();
        keyboard = '0; tick();
        keyboard = 10'b0000100000; tick(); tick();
        keyboard = '0; repeat (6) tick();
        n_cmp++; if (strobes - s0 !== 0) begin n_bad++; $display("FAIL bounce_strobe: got %0d expected 0", strobes - s0); end
        n_cmp++; if (en_lows - e0 !== 0) begin n_bad++; $display("FAIL bounce_enablen: got %0d expected 0", en_lows - e0); end
        n_cmp++; if (digits !== snap) begin n_bad++; $display("FAIL bounce_digits: got %h expected %h", digits, snap); end
        n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL bounce_state: got %0d expected %0d", dut.state, IDLE); end
    endtask

    task automatic test_multi_key();
        s0 = strobes;
        press(10'b0010001000, 10, 3);
        n_cmp++; if (strobes - s0 !== 0) begin n_bad++; $display("FAIL pair_strobe: got %0d expected 0", strobes - s0); end
        s0 = strobes; e0 = en_lows;
        press(10'b0000010000, 30, 3);
        n_cmp++; if (strobes - s0 !== 1) begin n_bad++; $display("FAIL held_strobe_count: got %0d expected 1", strobes - s0); end
        n_cmp++; if (en_lows - e0 !== 1) begin n_bad++; $display("FAIL held_enablen_count: got %0d expected 1", en_lows - e0); end
        n_cmp++; if (digits !== 16'h3074) begin n_bad++; $display("FAIL held_digits: got %h expected 3074", digits); end
    endtask

    task automatic test_lock();
        lock = 1'b1; s0 = strobes; e0 = en_lows; snap = digits;
        press(10'b1000000000, 10, 3);
        n_cmp++; if (strobes - s0 !== 0) begin n_bad++; $display("FAIL lock_strobe: got %0d expected 0", strobes - s0); end
        n_cmp++; if (en_lows - e0 !== 0) begin n_bad++; $display("FAIL lock_enablen: got %0d expected 0", en_lows - e0); end
        lock = 1'b0;
        keyboard = 10'b1000000000;
        tick(); tick(); tick();
        lock = 1'b1;
        tick();
        n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL lock_abort_state: got %0d expected %0d", dut.state, IDLE); end
        repeat (7) tick();
        keyboard = '0; repeat (3) tick();
        lock = 1'b0; tick();
        n_cmp++; if (strobes - s0 !== 0) begin n_bad++; $display("FAIL lock_abort_strobe: got %0d expected 0", strobes - s0); end
        n_cmp++; if (en_lows - e0 !== 0) begin n_bad++; $display("FAIL lock_abort_enablen: got %0d expected 0", en_lows - e0); end
        n_cmp++; if (digits !== snap) begin n_bad++; $display("FAIL lock_digits: got %h expected %h", digits, snap); end
    endtask

    task automatic test_bad_bcd();
        bad_mode = 1'b1; snap = digits; s0 = strobes; e0 = en_lows;
        press(10'b0000000010, 10, 3);
        bad_mode = 1'b0;
        n_cmp++; if (strobes - s0 !== 0) begin n_bad++; $display("FAIL badbcd_strobe: got %0d expected 0", strobes - s0); end
        n_cmp++; if (en_lows - e0 !== 1) begin n_bad++; $display("FAIL badbcd_enablen: got %0d expected 1", en_lows - e0); end
        n_cmp++; if (digits !== snap) begin n_bad++; $display("FAIL badbcd_digits: got %h expected %h", digits, snap); end
    endtask

    task automatic test_clear();
        do_reset();
        press(10'b0000010000, 8, 3);
        press(10'b0000100000, 8, 3);
        n_cmp++; if (digits !== 16'h0045) begin n_bad++; $display("FAIL clear_pre_digits: got %h expected 0045", digits); end
        s0 = strobes;
        keyboard = 10'b0100000000;
        repeat (6) tick();
        clear_entry = 1'b1;
        tick();
        clear_entry = 1'b0;
        n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL clear_digits: got %h expected 0000", digits); end
        n_cmp++; if (digit_strobe !== 1'b0) begin n_bad++; $display("FAIL clear_strobe: got %b expected 0", digit_strobe); end
        n_cmp++; if (entry_nonzero !== 1'b0) begin n_bad++; $display("FAIL clear_nonzero: got %b expected 0", entry_nonzero); end
        repeat (3) tick();
        keyboard = '0; repeat (3) tick();
        n_cmp++; if (strobes - s0 !== 0) begin n_bad++; $display("FAIL clear_strobe_count: got %0d expected 0", strobes - s0); end
    endtask

    task automatic test_reset_mid();
        press(10'b0001000000, 8, 3);
        n_cmp++; if (digits !== 16'h0006) begin n_bad++; $display("FAIL midrst_pre_digits: got %h expected 0006", digits); end
        keyboard = 10'b0000001000;
        tick(); tick(); tick();
        clearn = 1'b0;
        tick();
        n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL midrst_digits: got %h expected 0000", digits); end
        n_cmp++; if (digit_strobe !== 1'b0 || enc_enablen !== 1'b1) begin n_bad++; $display("FAIL midrst_ctrl: strobe %b enablen %b expected 0 1", digit_strobe, enc_enablen); end
        n_cmp++; if (enc_keyboard !== 10'h000 || entry_nonzero !== 1'b0) begin n_bad++; $display("FAIL midrst_outs: enc_keyboard %h nonzero %b expected 000 0", enc_keyboard, entry_nonzero); end
        n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL midrst_state: got %0d expected %0d", dut.state, IDLE); end
        keyboard = '0; clearn = 1'b1; repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_sequence();
        test_bounce();
        test_multi_key();
        test_lock();
        test_bad_bcd();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_entry_controller.md
Name: keypad_entry_controller

Overview:
Sequences the keypad-to-BCD encoder for the microwave time-entry path. It registers the raw 10-key keypad, debounces it, and rejects multi-key or empty patterns. It then enables the encoder for one cycle, captures the returned BCD digit and shifts it into a 4-digit MM:SS entry register. The entry register feeds the countdown timer. Keypad entry is locked out while cooking.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a one-hot key pattern must stay identical before it is accepted (min 2)
CNT_W, 3, debounce counter width; must hold DEBOUNCE_CYCLES-1

Ports:
clock  in  1  system clock, rising edge
clearn  in  1  synchronous active-low reset
keyboard  in  10  raw keypad; bit i high = key digit i pressed
lock  in  1  high while cooking; presses ignored
clear_entry  in  1  synchronous zeroing of the entry digits
enc_keyboard  out  10  registered keypad pattern driven to encoder keyboard input
enc_enablen  out  1  encoder enable, active low
enc_bcd  in  4  encoder BCD output
sec_ones  out  4  entry digit, seconds ones
sec_tens  out  4  entry digit, seconds tens
min_ones  out  4  entry digit, minutes ones
min_tens  out  4  entry digit, minutes tens
digit_strobe  out  1  one-cycle pulse when a digit is shifted in
entry_nonzero  out  1  combinational OR of all digit bits

Behaviour:
- Reset (clearn=0 at edge): state=IDLE, key_q=0, cnt=0, all digits=0, enc_enablen=1, digit_strobe=0. Reset takes effect mid-operation from any state.
- key_q <= keyboard every edge. enc_keyboard = key_q.
- onehot = key_q has exactly one bit set.
- FSM states: IDLE, DEBOUNCE, CAPTURE, WAIT_RELEASE.
- IDLE to DEBOUNCE when onehot && !lock. On this transition: pat <= key_q, cnt <= 0.
- DEBOUNCE:
  - lock=1 or key_q != pat: return to IDLE.
  - Otherwise, cnt==DEBOUNCE_CYCLES-1: go to CAPTURE.
  - Otherwise: cnt++.
- CAPTURE:
  - enc_enablen=0 for exactly this one cycle.
  - At the exit edge, enc_bcd is sampled. If enc_bcd<=9 and lock=0: shift, i.e. min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=enc_bcd, and digit_strobe<=1 for the next cycle.
  - If enc_bcd>9: no shift and no strobe.
  - Always goes to WAIT_RELEASE.
- WAIT_RELEASE goes to IDLE when key_q==0. A held key or added keys never produce a second digit.
- enc_enablen=1 in every state except CAPTURE.
- Latency: a stable single key first sampled at edge E0 updates the digits and raises digit_strobe at edge E0+DEBOUNCE_CYCLES+2 (edge E6 at default).
- clear_entry=1 zeroes all four digits at that edge. It has priority over a simultaneous shift, and that shift's strobe is suppressed. The FSM is unaffected.
- Overflow: a fifth digit discards the old min_tens; there is no saturation. Digit range is not checked against 59 seconds; the timer owns that.
- lock asserted in DEBOUNCE aborts to IDLE. lock asserted in CAPTURE suppresses the shift.
- Key patterns of 0 or of two or more bits never leave IDLE.

Decomposition:
- Shared package: FSM state encoding (2-bit localparams IDLE/DEBOUNCE/CAPTURE/WAIT_RELEASE), KEY_W=10, BCD_W=4, BCD_MAX=9.
- One natural sub-module, bcd_shift_reg4: the four digit registers with clear/shift-enable and strobe generation.
- The FSM and debounce counter stay in the top level.

Test Plan:
- Reset then key 0000000100 (digit 2) held 10 cycles, encoder model attached: at edge E6 sec_ones=2, digit_strobe high for exactly 1 cycle, enc_enablen low exactly 1 cycle; other digits stay 0.
- Sequence 1,2,3,0, each held 8 cycles with 3 idle cycles between: final min_tens=1, min_ones=2, sec_tens=3, sec_ones=0; entry_nonzero=1; exactly 4 strobes.
- Key 5 bouncing (high 2 cycles, low 1, high 2), then released: no strobe, digits unchanged, FSM back in IDLE.
- Keys 3 and 7 pressed together (0010001000) for 10 cycles, then key 4 alone held 30 cycles: no strobe for the pair; single strobe with sec_ones=4; no repeat while held.
- lock=1 with key 9 held 10 cycles: no strobe, enc_enablen stays 1. Repeat with lock rising during DEBOUNCE cycle 2: aborts, no strobe.
- Entry 4,5 present: clear_entry pulsed on the same edge a digit 8 shift would occur: all digits 0, digit_strobe stays 0, entry_nonzero=0. Also clearn low mid-DEBOUNCE returns all outputs to reset values at the next edge.
